// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage of the ARM-subset pipeline.
// Holds mode, opcode, ALU command and condition-code encodings plus the
// condition-evaluation helper used by the decoder.
package id_stage_pkg;

  localparam int NREG = 15;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_NOP = 2'b11
  } mode_e;

  // Data-processing opcodes (instruction[24:21])
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU commands driven to EXE
  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  // Condition codes (instruction[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv: N=bit3, Z=bit2, C=bit1, V=bit0. Code 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c & !z;
      COND_LS: cond_pass = !c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of everything crossing the ID stage boundary except clk/rst.
// slave  : the ID stage (consumes IF/ID, status, hazard and WB inputs,
//          produces the ID/EXE control and operand outputs).
// master : the surrounding pipeline / testbench.
interface id_stage_if #(parameter int DATA_W = 32);
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc_in;
  logic [3:0]        status;
  logic              hazard;
  logic              wb_en;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;

  logic              wb_en_out;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              b;
  logic              s;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        dest;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic              two_src;
  logic [DATA_W-1:0] pc_out;

  modport slave (
    input  instruction, pc_in, status, hazard, wb_en, wb_dest, wb_value,
    output wb_en_out, mem_r_en, mem_w_en, b, s, exe_cmd, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, src1, src2, two_src, pc_out
  );

  modport master (
    output instruction, pc_in, status, hazard, wb_en, wb_dest, wb_value,
    input  wb_en_out, mem_r_en, mem_w_en, b, s, exe_cmd, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, src1, src2, two_src, pc_out
  );
endinterface

// File: rtl/id_stage_register_file.sv
// 15 x DATA_W register file, two async read ports, one sync write port.
// Ports: clk, rst (sync, active-high, loads R[i]=i), wb_en/wb_dest/wb_value
// write port, src1/src2 read indices, val_rn/val_rm read data.
// Index 15 reads as zero and is never written. A same-cycle write to a
// read index is forwarded to the read port, except while rst is high.
module register_file
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_ok;

  assign wr_ok = wb_en && (wb_dest != 4'd15);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wb_dest] = wb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    val_rn = '0;
    if (src1 != 4'd15) begin
      val_rn = (wr_ok && !rst && wb_dest == src1) ? wb_value : regs_q[src1];
    end
  end

  always_comb begin
    val_rm = '0;
    if (src2 != 4'd15) begin
      val_rm = (wr_ok && !rst && wb_dest == src2) ? wb_value : regs_q[src2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage. Decodes the IF/ID instruction into EXE/MEM/WB
// control, gates control on the condition field and the hazard bubble, and
// reads Rn / second source from the register file written by WB.
// Ports: clk, rst, and the id_stage_if slave modport carrying all pipeline
// inputs and ID/EXE outputs. All outputs are combinational.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  logic [3:0] opcode;
  logic       s_bit;
  logic       i_bit;
  mode_e      mode;
  logic [3:0] cmd;
  logic       wb_dec, mr_dec, mw_dec, b_dec, s_dec;
  logic       kill;
  logic [3:0] src2_idx;

  assign opcode = bus.instruction[24:21];
  assign s_bit  = bus.instruction[20];
  assign i_bit  = bus.instruction[25];
  assign mode   = mode_e'(bus.instruction[27:26]);

  always_comb begin
    cmd    = EXE_NONE;
    wb_dec = 1'b0;
    mr_dec = 1'b0;
    mw_dec = 1'b0;
    b_dec  = 1'b0;
    s_dec  = 1'b0;
    case (mode)
      MODE_DP: begin
        wb_dec = 1'b1;
        s_dec  = s_bit;
        case (opcode)
          OP_MOV: cmd = EXE_MOV;
          OP_MVN: cmd = EXE_MVN;
          OP_ADD: cmd = EXE_ADD;
          OP_ADC: cmd = EXE_ADC;
          OP_SUB: cmd = EXE_SUB;
          OP_SBC: cmd = EXE_SBC;
          OP_AND: cmd = EXE_AND;
          OP_ORR: cmd = EXE_ORR;
          OP_EOR: cmd = EXE_EOR;
          OP_CMP: begin cmd = EXE_SUB; wb_dec = 1'b0; end
          OP_TST: begin cmd = EXE_AND; wb_dec = 1'b0; end
          default: begin
            wb_dec = 1'b0;
            s_dec  = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        cmd    = EXE_ADD;
        mr_dec = s_bit;
        wb_dec = s_bit;
        mw_dec = !s_bit;
      end
      MODE_BR:  b_dec = 1'b1;
      default: ;
    endcase
  end

  // Operand selection uses the unmasked store decode so the hazard unit
  // still sees the real sources of a squashed instruction.
  assign src2_idx = mw_dec ? bus.instruction[15:12] : bus.instruction[3:0];
  assign kill     = bus.hazard || !cond_pass(bus.instruction[31:28], bus.status);

  assign bus.wb_en_out     = wb_dec & !kill;
  assign bus.mem_r_en      = mr_dec & !kill;
  assign bus.mem_w_en      = mw_dec & !kill;
  assign bus.b             = b_dec  & !kill;
  assign bus.s             = s_dec  & !kill;
  assign bus.exe_cmd       = cmd;
  assign bus.imm           = i_bit;
  assign bus.shift_operand = bus.instruction[11:0];
  assign bus.signed_imm_24 = bus.instruction[23:0];
  assign bus.dest          = bus.instruction[15:12];
  assign bus.src1          = bus.instruction[19:16];
  assign bus.src2          = src2_idx;
  assign bus.two_src       = !i_bit | mw_dec;
  assign bus.pc_out        = bus.pc_in;

  register_file #(.DATA_W(DATA_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (bus.wb_en),
    .wb_dest  (bus.wb_dest),
    .wb_value (bus.wb_value),
    .src1     (bus.instruction[19:16]),
    .src2     (src2_idx),
    .val_rn   (bus.val_rn),
    .val_rm   (bus.val_rm)
  );

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  id_stage_if #(.DATA_W(32)) bus ();

  id_stage #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wb;
    logic       mr;
    logic       mw;
    logic       b;
    logic       s;
    logic [3:0] cmd;
    logic       two;
    logic [3:0] src2;
  } ctl_t;

  // Reference: opcode -> ALU command, -1 for opcodes the decoder rejects
  int          cmd_tab [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
  logic [31:0] mregs [15];

  function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] st);
    bit n, z, c, v;
    {n, z, c, v} = st;
    case (cc)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctl_t ref_ctl(input logic [31:0] ins, input logic [3:0] st, input logic hz);
    ctl_t e;
    int   op;
    e  = '0;
    op = int'(ins[24:21]);
    if (ins[27:26] == 2'd0) begin
      if (cmd_tab[op] >= 0) begin
        e.cmd = 4'(cmd_tab[op]);
        e.wb  = !(op == 10 || op == 8);
        e.s   = ins[20];
      end
    end else if (ins[27:26] == 2'd1) begin
      e.cmd = 4'd2;
      if (ins[20]) begin e.mr = 1; e.wb = 1; end
      else e.mw = 1;
    end else if (ins[27:26] == 2'd2) begin
      e.b = 1;
    end
    e.src2 = e.mw ? ins[15:12] : ins[3:0];
    e.two  = !ins[25] || e.mw;
    if (hz || !ref_cond(ins[31:28], st)) begin
      e.wb = 0; e.mr = 0; e.mw = 0; e.b = 0; e.s = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] ref_read(input logic [3:0] idx, input logic r,
                                           input logic we, input logic [3:0] wd,
                                           input logic [31:0] wv);
    if (idx == 4'd15) return 32'd0;
    if (we && !r && wd == idx) return wv;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] add_ins(input logic [3:0] rd, input logic [3:0] rn,
                                          input logic [3:0] rm);
    return {4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, rn, rd, 8'd0, rm};
  endfunction

  task automatic idle_inputs();
    bus.instruction = 32'hE000_0000;
    bus.pc_in = 32'h100; bus.status = 4'd0; bus.hazard = 0;
    bus.wb_en = 0; bus.wb_dest = 0; bus.wb_value = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 15; i++) begin
      bus.instruction = add_ins(4'd1, 4'(i), 4'(14 - i));
      #1;
      n_cmp++;
      if (bus.val_rn !== 32'(i)) begin
        n_bad++; $display("FAIL reset_rn[%0d] got %h want %h", i, bus.val_rn, 32'(i));
      end
      n_cmp++;
      if (bus.val_rm !== 32'(14 - i)) begin
        n_bad++; $display("FAIL reset_rm[%0d] got %h want %h", 14 - i, bus.val_rm, 32'(14 - i));
      end
    end
  endtask

  task automatic test_add();
    @(negedge clk); idle_inputs(); bus.instruction = 32'hE082_1003; #1;
    n_cmp++;
    if ({bus.exe_cmd, bus.dest, bus.wb_en_out, bus.two_src} !== {4'b0010, 4'd1, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL add_ctl got cmd=%b dest=%0d wb=%b two=%b want 0010/1/1/1",
                        bus.exe_cmd, bus.dest, bus.wb_en_out, bus.two_src);
    end
    n_cmp++;
    if ({bus.val_rn, bus.val_rm} !== {32'd2, 32'd3}) begin
      n_bad++; $display("FAIL add_ops got %h/%h want 2/3", bus.val_rn, bus.val_rm);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk); idle_inputs(); bus.instruction = 32'hE082_1003;
    bus.wb_en = 1; bus.wb_dest = 4'd2; bus.wb_value = 32'h55; #1;
    n_cmp++;
    if (bus.val_rn !== 32'h55) begin
      n_bad++; $display("FAIL bypass_same got %h want 55", bus.val_rn);
    end
    @(negedge clk); bus.wb_en = 0; #1;
    n_cmp++;
    if (bus.val_rn !== 32'h55) begin
      n_bad++; $display("FAIL bypass_stored got %h want 55", bus.val_rn);
    end
  endtask

  task automatic test_branch();
    @(negedge clk); idle_inputs(); bus.instruction = 32'h0A00_0004; bus.status = 4'b0000; #1;
    n_cmp++;
    if (bus.b !== 1'b0) begin n_bad++; $display("FAIL beq_z0 got %b want 0", bus.b); end
    bus.status = 4'b0100; #1;
    n_cmp++;
    if ({bus.b, bus.signed_imm_24} !== {1'b1, 24'h000004}) begin
      n_bad++; $display("FAIL beq_z1 got b=%b imm=%h want 1/000004", bus.b, bus.signed_imm_24);
    end
  endtask

  task automatic test_str_hazard();
    @(negedge clk); idle_inputs(); bus.instruction = 32'hE582_1000; #1;
    n_cmp++;
    if ({bus.mem_w_en, bus.src2, bus.two_src, bus.wb_en_out} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL str_ctl got mw=%b src2=%0d two=%b wb=%b want 1/1/1/0",
                        bus.mem_w_en, bus.src2, bus.two_src, bus.wb_en_out);
    end
    n_cmp++;
    if (bus.val_rm !== 32'd1) begin n_bad++; $display("FAIL str_rm got %h want 1", bus.val_rm); end
    bus.hazard = 1; #1;
    n_cmp++;
    if (bus.mem_w_en !== 1'b0) begin n_bad++; $display("FAIL str_hazard got %b want 0", bus.mem_w_en); end
  endtask

  task automatic test_cmp();
    @(negedge clk); idle_inputs(); bus.instruction = 32'hE152_0003; #1;
    n_cmp++;
    if ({bus.exe_cmd, bus.s, bus.wb_en_out} !== {4'b0100, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL cmp got cmd=%b s=%b wb=%b want 0100/1/0", bus.exe_cmd, bus.s, bus.wb_en_out);
    end
  endtask

  task automatic test_r15_and_reset();
    @(negedge clk); idle_inputs(); bus.instruction = add_ins(4'd1, 4'd15, 4'd15);
    bus.wb_en = 1; bus.wb_dest = 4'd15; bus.wb_value = 32'hFF; #1;
    n_cmp++;
    if ({bus.val_rn, bus.val_rm} !== 64'd0) begin
      n_bad++; $display("FAIL r15_bypass got %h/%h want 0/0", bus.val_rn, bus.val_rm);
    end
    @(negedge clk); bus.wb_en = 0; #1;
    n_cmp++;
    if (bus.val_rn !== 32'd0) begin n_bad++; $display("FAIL r15_read got %h want 0", bus.val_rn); end
    // Reset concurrent with a write to R2 (holding 0x55): no bypass, write discarded
    bus.instruction = 32'hE082_1003; rst = 1;
    bus.wb_en = 1; bus.wb_dest = 4'd2; bus.wb_value = 32'hAA; #1;
    n_cmp++;
    if (bus.val_rn !== 32'h55) begin n_bad++; $display("FAIL rst_no_bypass got %h want 55", bus.val_rn); end
    @(negedge clk); rst = 0; bus.wb_en = 0; #1;
    n_cmp++;
    if (bus.val_rn !== 32'd2) begin n_bad++; $display("FAIL rst_mid_write got %h want 2", bus.val_rn); end
  endtask

  task automatic test_random();
    ctl_t        exp_c, act_c;
    logic [31:0] ins, e_rn, e_rm;
    logic [75:0] exp_p, act_p;
    @(negedge clk); idle_inputs(); rst = 1;
    @(posedge clk);
    for (int i = 0; i < 15; i++) mregs[i] = 32'(i);
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      ins = $urandom;
      if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
      rst = ($urandom_range(0, 39) == 0);
      bus.instruction = ins;
      bus.pc_in = $urandom;
      bus.status = 4'($urandom);
      bus.hazard = ($urandom_range(0, 3) == 0);
      bus.wb_en = $urandom_range(0, 1);
      bus.wb_dest = 4'($urandom);
      bus.wb_value = $urandom;
      exp_c = ref_ctl(ins, bus.status, bus.hazard);
      e_rn = ref_read(ins[19:16], rst, bus.wb_en, bus.wb_dest, bus.wb_value);
      e_rm = ref_read(exp_c.src2, rst, bus.wb_en, bus.wb_dest, bus.wb_value);
      exp_p = {ins[25], ins[11:0], ins[23:0], ins[15:12], ins[19:16], bus.pc_in};
      #1;
      act_c = {bus.wb_en_out, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s,
               bus.exe_cmd, bus.two_src, bus.src2};
      act_p = {bus.imm, bus.shift_operand, bus.signed_imm_24, bus.dest, bus.src1, bus.pc_out};
      n_cmp++;
      if (act_c !== exp_c) begin
        n_bad++; $display("FAIL rnd_ctl[%0d] ins=%h st=%b hz=%b got %h want %h",
                          it, ins, bus.status, bus.hazard, act_c, exp_c);
      end
      n_cmp++;
      if (act_p !== exp_p) begin
        n_bad++; $display("FAIL rnd_fields[%0d] got %h want %h", it, act_p, exp_p);
      end
      n_cmp++;
      if ({bus.val_rn, bus.val_rm} !== {e_rn, e_rm}) begin
        n_bad++; $display("FAIL rnd_ops[%0d] ins=%h got %h/%h want %h/%h",
                          it, ins, bus.val_rn, bus.val_rm, e_rn, e_rm);
      end
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 15; i++) mregs[i] = 32'(i);
      end else if (bus.wb_en && bus.wb_dest != 4'd15) begin
        mregs[bus.wb_dest] = bus.wb_value;
      end
    end
    @(negedge clk); rst = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_bypass();
    test_branch();
    test_str_hazard();
    test_cmp();
    test_r15_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
